// File: rtl/program_loader.sv
// program_loader: streams a byte-wide program image into the 16x128 program RAM and verifies it by XOR checksum
module program_loader #(
    parameter int DEPTH = 128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  word_count,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        ram_read_en,
    output logic        ram_write_en,
    output logic [6:0]  ram_addr,
    output logic [15:0] ram_din,
    input  logic [15:0] ram_dout,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] checksum
);
    typedef enum logic [2:0] {IDLE, RECV_HI, RECV_LO, WRITE, VFY_RD, VFY_CMP, DONE} state_t;

    state_t      state, state_d;
    logic [6:0]  addr, addr_d, last, last_d;
    logic [15:0] word, word_d, checksum_d, acc, acc_d;
    logic        error_d;
    logic        is_last;

    // last holds word_count-1, so a 128-word load ends at address 127 without wrapping
    assign is_last = addr == last;

    // next-state and datapath updates; error is resolved on entry to DONE so it is valid alongside done
    always_comb begin
        state_d    = state;
        addr_d     = addr;
        last_d     = last;
        word_d     = word;
        checksum_d = checksum;
        acc_d      = acc;
        error_d    = error;
        case (state)
            IDLE: begin
                if (start) begin
                    if (word_count == 8'd0 || word_count > 8'(DEPTH)) begin
                        state_d = DONE;
                        error_d = 1'b1;
                    end else begin
                        state_d    = RECV_HI;
                        last_d     = 7'(word_count - 8'd1);
                        addr_d     = '0;
                        checksum_d = '0;
                        acc_d      = '0;
                        error_d    = 1'b0;
                    end
                end
            end
            RECV_HI: begin
                if (byte_valid) begin
                    word_d[15:8] = byte_data;
                    state_d      = RECV_LO;
                end
            end
            RECV_LO: begin
                if (byte_valid) begin
                    word_d[7:0] = byte_data;
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                checksum_d = checksum ^ word;
                addr_d     = is_last ? 7'd0 : addr + 7'd1;
                state_d    = is_last ? VFY_RD : RECV_HI;
            end
            VFY_RD: state_d = VFY_CMP;
            VFY_CMP: begin
                acc_d = acc ^ ram_dout;
                if (is_last) begin
                    state_d = DONE;
                    error_d = acc_d != checksum;
                end else begin
                    addr_d  = addr + 7'd1;
                    state_d = VFY_RD;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            addr     <= '0;
            last     <= '0;
            word     <= '0;
            checksum <= '0;
            acc      <= '0;
            error    <= 1'b0;
        end else begin
            state    <= state_d;
            addr     <= addr_d;
            last     <= last_d;
            word     <= word_d;
            checksum <= checksum_d;
            acc      <= acc_d;
            error    <= error_d;
        end
    end

    // registered outputs decoded from the next state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            byte_ready   <= 1'b0;
            ram_read_en  <= 1'b0;
            ram_write_en <= 1'b0;
            ram_addr     <= '0;
            ram_din      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            byte_ready   <= state_d == RECV_HI || state_d == RECV_LO;
            ram_read_en  <= state_d == VFY_RD;
            ram_write_en <= state_d == WRITE;
            ram_addr     <= (state_d == WRITE || state_d == VFY_RD) ? addr_d : '0;
            ram_din      <= state_d == WRITE ? word_d : '0;
            busy         <= state_d != IDLE;
            done         <= state_d == DONE;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for program_loader with a behavioural 16x128 RAM
module tb_program_loader;
    logic        clk = 0;
    logic        reset_n = 0;
    logic        start = 0;
    logic [7:0]  word_count = 0;
    logic [7:0]  byte_data = 0;
    logic        byte_valid = 0;
    logic        byte_ready, ram_read_en, ram_write_en, busy, done, error;
    logic [6:0]  ram_addr;
    logic [15:0] ram_din, ram_dout, checksum;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          done_cnt = 0;
    logic [6:0]  last_wr = 0;
    logic        corrupt = 0;
    logic [22:0] exp_q[$];
    logic [15:0] img [0:127];
    logic [15:0] mem [0:127];

    program_loader #(.DEPTH(128)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .word_count(word_count),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .ram_read_en(ram_read_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy), .done(done),
        .error(error), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // cycle counter for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model with registered read; optionally corrupts address 1 on write
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_addr] <= (corrupt && ram_addr == 7'd1) ? ram_din ^ 16'h0001 : ram_din;
        if (ram_read_en) ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // write scoreboard and handshake exclusivity monitor
    always @(negedge clk) begin
        if (reset_n) begin
            if (ram_write_en) begin
                wr_cnt++;
                last_wr = ram_addr;
                check("wr_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    logic [22:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(ram_addr), 32'(e[22:16]));
                    check("wr_data", 32'(ram_din), 32'(e[15:0]));
                end
            end
            if (ram_read_en) rd_cnt++;
            if (done) done_cnt++;
            if (ram_write_en || ram_read_en) begin
                check("rdy_excl", 32'(byte_ready), 0);
                check("en_excl", 32'(ram_write_en && ram_read_en), 0);
            end
        end
    end

    task automatic outputs_zero(input string tag);
        check({tag, "_rdy"}, 32'(byte_ready), 0);
        check({tag, "_ren"}, 32'(ram_read_en), 0);
        check({tag, "_wen"}, 32'(ram_write_en), 0);
        check({tag, "_addr"}, 32'(ram_addr), 0);
        check({tag, "_din"}, 32'(ram_din), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(error), 0);
        check({tag, "_ck"}, 32'(checksum), 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bp);
        if (bp) begin
            byte_valid = 0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        byte_data  = b;
        byte_valid = 1;
        for (int t = 0; t < 50 && !byte_ready; t++) @(negedge clk);
        check("hs_ready", 32'(byte_ready), 1);
        @(negedge clk);
    endtask

    task automatic run_load(input int n, input bit bp, input bit exp_err);
        logic [15:0] ck;
        int c0, d0;
        ck = 0;
        for (int k = 0; k < n; k++) begin
            ck ^= img[k];
            exp_q.push_back({7'(k), img[k]});
        end
        check("busy_idle", 32'(busy), 0);
        d0 = done_cnt;
        c0 = cyc;
        start = 1;
        word_count = 8'(n);
        @(negedge clk);
        start = 0;
        check("busy_rise", 32'(busy), 1);
        check("err_clr", 32'(error), 0);
        for (int k = 0; k < n; k++) begin
            send_byte(img[k][15:8], bp);
            send_byte(img[k][7:0], bp);
        end
        byte_valid = 0;
        for (int t = 0; t < 3000 && !done; t++) @(negedge clk);
        check("done", 32'(done), 1);
        if (!bp) check("latency", 32'(cyc - c0), 32'(1 + 5 * n));
        check("error", 32'(error), 32'(exp_err));
        check("checksum", 32'(checksum), 32'(ck));
        check("busy_at_done", 32'(busy), 1);
        @(negedge clk);
        #1;
        check("done_pulse", 32'(done), 0);
        check("busy_fall", 32'(busy), 0);
        check("done_cnt", 32'(done_cnt - d0), 1);
        check("wr_all", 32'(exp_q.size()), 0);
    endtask

    task automatic illegal(input int n);
        int w0, r0;
        w0 = wr_cnt;
        r0 = rd_cnt;
        start = 1;
        word_count = 8'(n);
        @(negedge clk);
        start = 0;
        for (int t = 0; t < 2 && !done; t++) @(negedge clk);
        check("ill_done", 32'(done), 1);
        check("ill_err", 32'(error), 1);
        @(negedge clk);
        #1;
        check("ill_pulse", 32'(done), 0);
        check("ill_busy", 32'(busy), 0);
        check("ill_wr", 32'(wr_cnt - w0), 0);
        check("ill_rd", 32'(rd_cnt - r0), 0);
    endtask

    task automatic set_basic();
        img[0] = 16'h1884;
        img[1] = 16'h1906;
        img[2] = 16'h0194;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        outputs_zero("reset");
        reset_n = 1;
        @(negedge clk);

        set_basic();
        run_load(3, 0, 0);
        check("basic_ck", 32'(checksum), 32'h0016);
        check("basic_last", 32'(last_wr), 2);

        run_load(3, 1, 0);

        illegal(0);
        illegal(200);

        for (int k = 0; k < 128; k++) img[k] = 16'hA500 | 16'(k);
        run_load(128, 0, 0);
        check("full_last", 32'(last_wr), 127);

        set_basic();
        corrupt = 1;
        run_load(3, 0, 1);
        corrupt = 0;
        run_load(3, 0, 0);

        for (int k = 0; k < 3; k++) exp_q.push_back({7'(k), img[k]});
        start = 1;
        word_count = 8'd3;
        @(negedge clk);
        start = 0;
        send_byte(img[0][15:8], 0);
        send_byte(img[0][7:0], 0);
        send_byte(img[1][15:8], 0);
        send_byte(img[1][7:0], 0);
        send_byte(img[2][15:8], 0);
        check("mid_recv_lo", 32'(byte_ready), 1);
        reset_n = 0;
        byte_valid = 0;
        @(negedge clk);
        outputs_zero("midrst");
        exp_q.delete();
        reset_n = 1;
        @(negedge clk);
        img[0] = 16'h0F0F;
        img[1] = 16'h1234;
        img[2] = 16'hFFFF;
        run_load(3, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
